// File: rtl/ex_mem_pkg.sv
// Shared layout for the elastic EX/MEM register: default field widths, the packed
// payload bundle {func3, mem_re, mem_we, reg_en, rd, store_data, alu} and its bit offsets.
package ex_mem_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;
  localparam int F3_W_DEF = 3;

  // Occupancy doubles as the control state of the two-slot buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  function automatic int sd_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int rd_lsb(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int regen_bit(input int xlen, input int ra_w);
    return 2 * xlen + ra_w;
  endfunction

  function automatic int we_bit(input int xlen, input int ra_w);
    return 2 * xlen + ra_w + 1;
  endfunction

  function automatic int re_bit(input int xlen, input int ra_w);
    return 2 * xlen + ra_w + 2;
  endfunction

  function automatic int f3_lsb(input int xlen, input int ra_w);
    return 2 * xlen + ra_w + 3;
  endfunction

  function automatic int bundle_w(input int xlen, input int ra_w, input int f3_w);
    return 2 * xlen + ra_w + 3 + f3_w;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One buffer entry: a valid flag plus a payload word. Clear beats load so a flush
// always wins; clearing leaves the payload untouched so outputs hold their last value.
module ex_mem_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      // NOTE: the payload is reset too, so MEM reads all-zero data right after reset.
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_elastic.sv
// Elastic EX/MEM pipeline register with valid/ready handshake, flush and an optional
// two-entry skid buffer that keeps MEM back-pressure off the combinational EX ready path.
module ex_mem_elastic
  import ex_mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF,
  parameter int F3_W = F3_W_DEF,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [RA_W-1:0] rd_addr_in,
  input  logic            reg_enable_in,
  input  logic            mem_we_in,
  input  logic            mem_re_in,
  input  logic [F3_W-1:0] func3_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [RA_W-1:0] rd_addr_out,
  output logic [F3_W-1:0] func3_out,
  output logic            reg_enable_out,
  output logic            mem_we_out,
  output logic            mem_re_out,
  output logic            fwd_valid,
  output logic            load_pending,
  output logic [1:0]      occupancy
);

  localparam int BW        = bundle_w(XLEN, RA_W, F3_W);
  localparam int SD_LSB    = sd_lsb(XLEN);
  localparam int RD_LSB    = rd_lsb(XLEN);
  localparam int REGEN_BIT = regen_bit(XLEN, RA_W);
  localparam int WE_BIT    = we_bit(XLEN, RA_W);
  localparam int RE_BIT    = re_bit(XLEN, RA_W);
  localparam int F3_LSB    = f3_lsb(XLEN, RA_W);

  logic [BW-1:0] w_in_bundle;
  logic [BW-1:0] w_m_din;
  logic [BW-1:0] w_m_data;
  logic [BW-1:0] w_s_data;
  logic          w_m_valid;
  logic          w_s_valid;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_m_load;
  logic          w_m_clear;
  logic          w_m_src_s;
  logic          w_s_load;
  logic          w_s_clear;
  occ_e          w_state;

  assign w_in_bundle = {func3_in, mem_re_in, mem_we_in, reg_enable_in,
                        rd_addr_in, store_data_in, alu_in};

  // With the skid slot, ready depends only on a flop; without it, MEM ready passes straight through.
  assign in_ready   = (SKID != 0) ? ~w_s_valid : (out_ready | ~w_m_valid);
  assign out_valid  = w_m_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_m_valid & out_ready;

  always_comb begin
    w_state = OCC_EMPTY;
    if (w_s_valid)      w_state = OCC_FULL;
    else if (w_m_valid) w_state = OCC_ONE;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_m_load  = 1'b0;
    w_m_clear = flush;
    w_m_src_s = 1'b0;
    w_s_load  = 1'b0;
    w_s_clear = flush;
    if (SKID != 0) begin
      case (w_state)
        OCC_EMPTY: begin
          w_m_load = w_in_fire;
        end
        OCC_ONE: begin
          if (w_in_fire && w_out_fire) w_m_load  = 1'b1;
          else if (w_in_fire)          w_s_load  = 1'b1;
          else if (w_out_fire)         w_m_clear = 1'b1;
        end
        OCC_FULL: begin
          if (w_out_fire) begin
            w_m_load  = 1'b1;
            w_m_src_s = 1'b1;
            w_s_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      w_m_load  = w_in_fire;
      w_m_clear = flush | (w_out_fire & ~w_in_fire);
    end
  end

  assign w_m_din = w_m_src_s ? w_s_data : w_in_bundle;

  ex_mem_slot #(.W(BW)) u_slot_m (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_m_load),
    .i_clear (w_m_clear),
    .i_data  (w_m_din),
    .o_valid (w_m_valid),
    .o_data  (w_m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      ex_mem_slot #(.W(BW)) u_slot_s (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_data  (w_in_bundle),
        .o_valid (w_s_valid),
        .o_data  (w_s_data)
      );
    end else begin : g_no_skid
      assign w_s_valid = 1'b0;
      assign w_s_data  = '0;
    end
  endgenerate

  assign alu_out        = w_m_data[XLEN-1:0];
  assign store_data_out = w_m_data[SD_LSB +: XLEN];
  assign rd_addr_out    = w_m_data[RD_LSB +: RA_W];
  assign func3_out      = w_m_data[F3_LSB +: F3_W];
  assign reg_enable_out = w_m_valid & w_m_data[REGEN_BIT];
  assign mem_we_out     = w_m_valid & w_m_data[WE_BIT];
  assign mem_re_out     = w_m_valid & w_m_data[RE_BIT];
  assign fwd_valid      = reg_enable_out & (rd_addr_out != '0);
  assign load_pending   = mem_re_out;
  assign occupancy      = w_state;

endmodule

// File: doc/ex_mem_elastic.md
Name: ex_mem_elastic

Overview:
- Parametrised successor to the fixed EX/MEM pipeline register.
- Adds a valid/ready handshake, a flush input and an optional 2-entry skid buffer, so MEM back-pressure (for example a wait-stated peripheral bus) does not create a combinational ready path into EX.
- Exports forwarding and load-hazard information taken from the entry currently presented to MEM.
- Sits between the EX stage and the MEM stage of the riscv32i core.

Parameters:
- XLEN, 32, data width of the ALU result and store data.
- RA_W, 5, register-address width.
- F3_W, 3, width of the func3 field.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single slot with combinational in_ready.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  EX presents a beat.
- in_ready  out  1  block can accept a beat.
- alu_in  in  XLEN  ALU result or address.
- store_data_in  in  XLEN  store data.
- rd_addr_in  in  RA_W  destination register.
- reg_enable_in  in  1  register-file write enable.
- mem_we_in  in  1  memory write.
- mem_re_in  in  1  memory read.
- func3_in  in  F3_W  access size/sign.
- out_valid  out  1  MEM beat valid.
- out_ready  in  1  MEM accepts the beat.
- alu_out  out  XLEN  registered ALU result.
- store_data_out  out  XLEN  registered store data.
- rd_addr_out  out  RA_W  registered destination register.
- func3_out  out  F3_W  registered func3.
- reg_enable_out  out  1  reg_enable, qualified with out_valid.
- mem_we_out  out  1  mem_we, qualified with out_valid.
- mem_re_out  out  1  mem_re, qualified with out_valid.
- fwd_valid  out  1  out_valid & reg_enable_out & (rd_addr_out != 0).
- load_pending  out  1  out_valid & mem_re_out, for the hazard unit.
- occupancy  out  2  entries held (0..2).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. On reset, all valids are 0, all data registers are 0, occupancy is 0 and in_ready is 1 on the next cycle. Reset asserted mid-transfer drops every entry.
- Handshake:
  - A beat transfers in when in_valid & in_ready at a rising edge.
  - A beat transfers out when out_valid & out_ready.
  - Data is presented with zero combinational path from inputs to outputs; latency is 1 cycle when empty.
- Control qualification: when out_valid = 0, reg_enable_out, mem_we_out and mem_re_out are 0. Data outputs hold their last value.
- Ordering: entries leave in arrival order; no duplication, no loss.
- SKID = 1: main slot M drives the outputs; skid slot S holds overflow.
  - States: EMPTY (occupancy 0), ONE (M valid), FULL (M and S valid).
  - in_ready = ~S.valid, a registered signal.
  - EMPTY + in -> ONE.
  - ONE + in & out -> ONE; M takes the new beat.
  - ONE + in & ~out -> FULL; S takes the new beat.
  - ONE + out & ~in -> EMPTY.
  - FULL + out -> ONE; M takes S.
  - FULL: in_ready = 0, so no acceptance.
- SKID = 0: single slot M.
  - in_ready = out_ready | ~M.valid, combinational.
  - occupancy is 0 or 1.
- Flush: highest priority after reset. At the edge where flush = 1, both slots are cleared and any beat handshaking in that cycle is discarded. In the same cycle, out_valid still shows the current entry; MEM is responsible for ignoring it. occupancy is 0 next cycle.
- Simultaneous in and out in FULL: impossible, because in_ready = 0.
- out_ready is don't-care when out_valid = 0.
- Output data must not change while out_valid & ~out_ready, so MEM always sees stable values.

Decomposition:
- Shared header ex_mem_pkg.vh holds:
  - localparam field widths;
  - a packed bundle layout, {func3, mem_re, mem_we, reg_en, rd, store_data, alu}, with offsets;
  - BUNDLE_W.
- One sub-module, ex_mem_slot: valid bit plus BUNDLE_W payload, with load, clear and synchronous reset. It is instanced twice when SKID = 1.

Test Plan:
- Reset with in_valid = 1 -> cycle after reset deassert: out_valid = 0, all outputs 0, in_ready = 1, occupancy = 0.
- Streaming, SKID = 1, out_ready = 1, 8 beats with alu_in = 0x100..0x107 -> out_valid one cycle later every cycle; alu_out sequence 0x100..0x107; occupancy never exceeds 1.
- Back-pressure: out_ready = 0, send beats A = 0x10 and B = 0x20 -> occupancy = 2, in_ready = 0; alu_out holds 0x10. Raise out_ready -> A then B appear, and in_ready returns to 1 the cycle after A leaves.
- Flush while FULL with a third beat C offered -> next cycle out_valid = 0, occupancy = 0, mem_we_out = 0; C never appears.
- Forwarding/hazard: load beat with rd = 5, mem_re = 1, reg_enable = 1 -> fwd_valid = 1, load_pending = 1. Beat with rd = 0, reg_enable = 1 -> fwd_valid = 0.
- SKID = 0 build: out_ready = 0 with M valid -> in_ready = 0 in the same cycle. Toggle out_ready with in_valid held high -> no beat is lost or duplicated (scoreboard check).
